washer_panel_ctrl: RTL and testbench

User-facing front end of the washing machine, sitting directly upstream of the washing machine controller FSM. It synchronizes and debounces raw panel buttons and the door sensor, classifies the load sensor into presence and weight class, and tracks the run/pause/done session. From these it drives the controller's `Start`, `Pause`, `Stop`, `Operation`, `Weight`, `Open_Door`, `Close_Door` and `Clothes_in` inputs, and consumes its `Finish`/`Failure` outputs to lock and unlock the door.

---
 rtl/washer_pkg.sv | 39 +++
 rtl/button_debouncer.sv | 51 +++++
 rtl/washer_panel_ctrl.sv | 155 +++++++++++++++
 tb/tb_washer_panel_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared definitions for the washer panel front end and the washer controller.
//   - panel_state_t : panel session FSM encodings
//   - OP_*          : Operation codes driven to the controller
//   - W_*           : Weight class codes driven to the controller
//   - weight_class  : maps a load reading onto a weight class
package washer_pkg;

    localparam int unsigned LOAD_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned WGT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } panel_state_t;

    localparam logic [OP_W-1:0] OP_NORMAL     = 2'd0;
    localparam logic [OP_W-1:0] OP_WASH       = 2'd1;
    localparam logic [OP_W-1:0] OP_RINSE_SPIN = 2'd2;
    localparam logic [OP_W-1:0] OP_SPIN       = 2'd3;

    localparam logic [WGT_W-1:0] W_LIGHT  = 2'd0;
    localparam logic [WGT_W-1:0] W_MEDIUM = 2'd1;
    localparam logic [WGT_W-1:0] W_HEAVY  = 2'd2;

    // Light below t1, medium below t2, heavy otherwise; code 3 never produced.
    function automatic logic [WGT_W-1:0] weight_class(
        input logic [LOAD_W-1:0] load,
        input logic [LOAD_W-1:0] t1,
        input logic [LOAD_W-1:0] t2
    );
        if (load < t1)      return W_LIGHT;
        else if (load < t2) return W_MEDIUM;
        else                return W_HEAVY;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizer + debouncer for one raw asynchronous input.
//   CLK   : system clock
//   RST   : synchronous active-high reset
//   raw   : asynchronous input
//   level : debounced level (reset 0)
//   rise  : one-cycle strobe coincident with a 0->1 change of level
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge;
    // any matching cycle restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_2;
                    rise  <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/washer_panel_ctrl.sv
// Washer user panel: debounces buttons/door, classifies load, and runs the
// IDLE/RUN/PAUSED/DONE session that drives the washer controller inputs.
//   CLK, RST                      : clock, synchronous active-high reset
//   Btn_Start/Pause/Stop/Mode     : raw buttons, 1 = pressed
//   Door_Sensor                   : raw door, 1 = closed
//   Load_Sensor[7:0]              : load cell reading
//   Finish, Failure               : controller status
//   Start, Stop                   : one-cycle command pulses
//   Pause                         : high while paused
//   Operation[1:0], Weight[1:0]   : program / weight class
//   Open_Door, Close_Door         : debounced door state (complementary)
//   Clothes_in                    : load present
//   Door_Lock, Busy               : lock solenoid, session active
module washer_panel_ctrl
    import washer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOAD_MIN        = 8,
    parameter int unsigned WEIGHT_T1       = 64,
    parameter int unsigned WEIGHT_T2       = 160
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Start,
    input  logic       Btn_Pause,
    input  logic       Btn_Stop,
    input  logic       Btn_Mode,
    input  logic       Door_Sensor,
    input  logic [7:0] Load_Sensor,
    input  logic       Finish,
    input  logic       Failure,
    output logic       Start,
    output logic       Stop,
    output logic       Pause,
    output logic [1:0] Operation,
    output logic [1:0] Weight,
    output logic       Open_Door,
    output logic       Close_Door,
    output logic       Clothes_in,
    output logic       Door_Lock,
    output logic       Busy
);

    logic start_press, pause_press, stop_press, mode_press;
    logic door_closed;
    logic start_lvl_unused, pause_lvl_unused, stop_lvl_unused, mode_lvl_unused;
    logic door_rise_unused;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .CLK(CLK), .RST(RST), .raw(Btn_Start), .level(start_lvl_unused), .rise(start_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .CLK(CLK), .RST(RST), .raw(Btn_Pause), .level(pause_lvl_unused), .rise(pause_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .CLK(CLK), .RST(RST), .raw(Btn_Stop), .level(stop_lvl_unused), .rise(stop_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .CLK(CLK), .RST(RST), .raw(Btn_Mode), .level(mode_lvl_unused), .rise(mode_press));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
        .CLK(CLK), .RST(RST), .raw(Door_Sensor), .level(door_closed), .rise(door_rise_unused));

    // Door outputs come straight from the debounced door register.
    assign Close_Door = door_closed;
    assign Open_Door  = ~door_closed;

    panel_state_t      state_q, state_d;
    logic              start_d, stop_d, pause_d;
    logic [OP_W-1:0]   op_d;
    logic [WGT_W-1:0]  weight_d;

    // Session next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        pause_d  = Pause;
        op_d     = Operation;
        weight_d = Weight;
        unique case (state_q)
            ST_IDLE: begin
                pause_d  = 1'b0;
                weight_d = weight_class(Load_Sensor, LOAD_W'(WEIGHT_T1), LOAD_W'(WEIGHT_T2));
                if (start_press) begin
                    // Start beats Mode; a refused start is simply dropped.
                    if (door_closed && Clothes_in) begin
                        start_d  = 1'b1;
                        state_d  = ST_RUN;
                        weight_d = Weight;
                    end
                end else if (mode_press) begin
                    op_d = OP_W'(Operation + OP_W'(1));
                end
            end
            ST_RUN: begin
                if (stop_press) begin
                    stop_d  = 1'b1;
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (Failure) begin
                    state_d = ST_IDLE;
                end else if (Finish) begin
                    state_d = ST_DONE;
                end else if (pause_press) begin
                    pause_d = 1'b1;
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (stop_press) begin
                    stop_d  = 1'b1;
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (Failure) begin
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (pause_press) begin
                    pause_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!door_closed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Output registers; lock/busy follow the session state one edge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Start      <= 1'b0;
            Stop       <= 1'b0;
            Pause      <= 1'b0;
            Operation  <= OP_NORMAL;
            Weight     <= W_LIGHT;
            Clothes_in <= 1'b0;
            Door_Lock  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Start      <= start_d;
            Stop       <= stop_d;
            Pause      <= pause_d;
            Operation  <= op_d;
            Weight     <= weight_d;
            Clothes_in <= (Load_Sensor >= LOAD_W'(LOAD_MIN));
            Door_Lock  <= (state_q == ST_RUN) || (state_q == ST_PAUSED);
            Busy       <= (state_q == ST_RUN) || (state_q == ST_PAUSED);
        end
    end

endmodule

// File: tb/tb_washer_panel_ctrl.sv
// Directed bench for washer_panel_ctrl at default parameters (D = 4).
// Inputs change and outputs are sampled on the falling edge.
module tb_washer_panel_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Btn_Start, Btn_Pause, Btn_Stop, Btn_Mode, Door_Sensor;
    logic [7:0] Load_Sensor;
    logic       Finish, Failure;
    logic       Start, Stop, Pause;
    logic [1:0] Operation, Weight;
    logic       Open_Door, Close_Door, Clothes_in, Door_Lock, Busy;

    int total = 0;
    int bad   = 0;

    washer_panel_ctrl dut (
        .CLK(CLK), .RST(RST),
        .Btn_Start(Btn_Start), .Btn_Pause(Btn_Pause), .Btn_Stop(Btn_Stop), .Btn_Mode(Btn_Mode),
        .Door_Sensor(Door_Sensor), .Load_Sensor(Load_Sensor),
        .Finish(Finish), .Failure(Failure),
        .Start(Start), .Stop(Stop), .Pause(Pause),
        .Operation(Operation), .Weight(Weight),
        .Open_Door(Open_Door), .Close_Door(Close_Door), .Clothes_in(Clothes_in),
        .Door_Lock(Door_Lock), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // {Start,Stop,Pause,Operation,Weight,Door_Lock,Busy,Clothes_in,Open_Door,Close_Door}
    localparam logic [11:0] RESET_VEC = 12'b0_0_0_00_00_0_0_0_1_0;

    task automatic test_reset();
        logic [11:0] v;
        RST = 1'b1; Btn_Start = 0; Btn_Pause = 0; Btn_Stop = 0; Btn_Mode = 0;
        Door_Sensor = 0; Load_Sensor = 8'd0; Finish = 0; Failure = 0;
        step(2);
        v = {Start, Stop, Pause, Operation, Weight, Door_Lock, Busy, Clothes_in, Open_Door, Close_Door};
        total++; if (v !== RESET_VEC) begin bad++; $display("FAIL reset_vec got=%b exp=%b", v, RESET_VEC); end
        RST = 1'b0; Door_Sensor = 1'b1;
        step(5);
        total++; if (Close_Door !== 1'b0) begin bad++; $display("FAIL door_edge5 got=%b exp=0", Close_Door); end
        step(1);
        total++; if (Close_Door !== 1'b1) begin bad++; $display("FAIL door_edge6 got=%b exp=1", Close_Door); end
        total++; if (Open_Door !== 1'b0) begin bad++; $display("FAIL open_door_edge6 got=%b exp=0", Open_Door); end
    endtask

    task automatic test_mode_start();
        int n;
        Load_Sensor = 8'd100;
        step(1);
        total++; if (Clothes_in !== 1'b1) begin bad++; $display("FAIL clothes_100 got=%b exp=1", Clothes_in); end
        total++; if (Weight !== 2'd1) begin bad++; $display("FAIL weight_100 got=%0d exp=1", Weight); end
        for (int i = 0; i < 5; i++) begin
            Btn_Mode = 1'b1; step(6);
            Btn_Mode = 1'b0; step(6);
        end
        total++; if (Operation !== 2'd1) begin bad++; $display("FAIL mode_x5 got=%0d exp=1", Operation); end
        Btn_Start = 1'b1;
        step(6);
        total++; if (Start !== 1'b0) begin bad++; $display("FAIL start_early got=%b exp=0", Start); end
        step(1);
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start_edge7 got=%b exp=1", Start); end
        step(1);
        total++; if (Start !== 1'b0) begin bad++; $display("FAIL start_width got=%b exp=0", Start); end
        total++; if ({Door_Lock, Busy} !== 2'b11) begin bad++; $display("FAIL run_lock_busy got=%b exp=11", {Door_Lock, Busy}); end
        n = 0;
        for (int i = 0; i < 10; i++) begin step(1); n += int'(Start); end
        Btn_Start = 1'b0;
        for (int i = 0; i < 8; i++) begin step(1); n += int'(Start); end
        total++; if (n !== 0) begin bad++; $display("FAIL start_held_repulse got=%0d exp=0", n); end
        Load_Sensor = 8'd200;
        step(2);
        total++; if ({Operation, Weight} !== 4'b0101) begin bad++; $display("FAIL run_frozen got=%b exp=0101", {Operation, Weight}); end
        Load_Sensor = 8'd100;
        step(1);
    endtask

    task automatic test_pause_stop();
        int n;
        Btn_Pause = 1'b1;
        step(6);
        total++; if (Pause !== 1'b0) begin bad++; $display("FAIL pause_early got=%b exp=0", Pause); end
        step(1);
        total++; if (Pause !== 1'b1) begin bad++; $display("FAIL pause_on got=%b exp=1", Pause); end
        step(2);
        Btn_Pause = 1'b0;
        step(6);
        total++; if ({Pause, Door_Lock, Busy} !== 3'b111) begin bad++; $display("FAIL paused_hold got=%b exp=111", {Pause, Door_Lock, Busy}); end
        Btn_Pause = 1'b1;
        step(7);
        total++; if ({Pause, Busy} !== 2'b01) begin bad++; $display("FAIL resume got=%b exp=01", {Pause, Busy}); end
        Btn_Pause = 1'b0;
        step(6);
        // Stop press strobe and Finish land on the same edge: Stop wins.
        Btn_Stop = 1'b1;
        step(6);
        Finish = 1'b1;
        step(1);
        Finish = 1'b0;
        total++; if (Stop !== 1'b1) begin bad++; $display("FAIL stop_vs_finish got=%b exp=1", Stop); end
        step(1);
        total++; if ({Stop, Door_Lock, Busy} !== 3'b000) begin bad++; $display("FAIL after_stop got=%b exp=000", {Stop, Door_Lock, Busy}); end
        n = 0;
        for (int i = 0; i < 4; i++) begin step(1); n += int'(Stop) + int'(Busy); end
        Btn_Stop = 1'b0;
        for (int i = 0; i < 6; i++) begin step(1); n += int'(Stop) + int'(Busy); end
        total++; if (n !== 0) begin bad++; $display("FAIL stop_idle_settle got=%0d exp=0", n); end
    endtask

    task automatic test_glitch_noload();
        int n;
        Btn_Start = 1'b1;
        step(3);
        Btn_Start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin step(1); n += int'(Start) + int'(Busy); end
        total++; if (n !== 0) begin bad++; $display("FAIL glitch got=%0d exp=0", n); end
        Load_Sensor = 8'd4;
        step(1);
        total++; if ({Clothes_in, Weight} !== 3'b000) begin bad++; $display("FAIL load4 got=%b exp=000", {Clothes_in, Weight}); end
        Btn_Start = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin step(1); n += int'(Start) + int'(Busy) + int'(Door_Lock); end
        Btn_Start = 1'b0;
        for (int i = 0; i < 6; i++) begin step(1); n += int'(Start) + int'(Busy) + int'(Door_Lock); end
        total++; if (n !== 0) begin bad++; $display("FAIL start_no_load got=%0d exp=0", n); end
        Load_Sensor = 8'd100;
        step(1);
    endtask

    task automatic test_finish();
        Btn_Start = 1'b1;
        step(7);
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start2 got=%b exp=1", Start); end
        step(1);
        Btn_Start = 1'b0;
        step(6);
        Finish = 1'b1;
        step(1);
        Finish = 1'b0;
        total++; if (Door_Lock !== 1'b1) begin bad++; $display("FAIL lock_finish_edge1 got=%b exp=1", Door_Lock); end
        step(1);
        total++; if ({Door_Lock, Busy} !== 2'b00) begin bad++; $display("FAIL lock_finish_edge2 got=%b exp=00", {Door_Lock, Busy}); end
        Load_Sensor = 8'd200;
        step(2);
        total++; if (Weight !== 2'd1) begin bad++; $display("FAIL done_weight_hold got=%0d exp=1", Weight); end
        Door_Sensor = 1'b0;
        step(5);
        total++; if (Open_Door !== 1'b0) begin bad++; $display("FAIL open_edge5 got=%b exp=0", Open_Door); end
        step(1);
        total++; if ({Open_Door, Close_Door} !== 2'b10) begin bad++; $display("FAIL open_edge6 got=%b exp=10", {Open_Door, Close_Door}); end
        step(2);
        total++; if (Weight !== 2'd2) begin bad++; $display("FAIL idle_weight_200 got=%0d exp=2", Weight); end
        Door_Sensor = 1'b1;
        step(6);
        total++; if (Close_Door !== 1'b1) begin bad++; $display("FAIL reclose got=%b exp=1", Close_Door); end
    endtask

    task automatic test_failure_reset();
        logic [11:0] v;
        Btn_Start = 1'b1;
        step(7);
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start3 got=%b exp=1", Start); end
        step(1);
        Btn_Start = 1'b0;
        step(6);
        Btn_Pause = 1'b1;
        step(7);
        total++; if (Pause !== 1'b1) begin bad++; $display("FAIL pause3 got=%b exp=1", Pause); end
        Btn_Pause = 1'b0;
        step(6);
        Failure = 1'b1;
        step(1);
        total++; if ({Pause, Busy} !== 2'b01) begin bad++; $display("FAIL fail_edge1 got=%b exp=01", {Pause, Busy}); end
        step(1);
        Failure = 1'b0;
        total++; if ({Busy, Door_Lock, Stop} !== 3'b000) begin bad++; $display("FAIL fail_edge2 got=%b exp=000", {Busy, Door_Lock, Stop}); end
        Btn_Start = 1'b1;
        step(7);
        total++; if (Start !== 1'b1) begin bad++; $display("FAIL start4 got=%b exp=1", Start); end
        step(1);
        Btn_Start = 1'b0;
        step(6);
        total++; if ({Busy, Weight} !== 3'b110) begin bad++; $display("FAIL run4 got=%b exp=110", {Busy, Weight}); end
        RST = 1'b1;
        step(1);
        v = {Start, Stop, Pause, Operation, Weight, Door_Lock, Busy, Clothes_in, Open_Door, Close_Door};
        total++; if (v !== RESET_VEC) begin bad++; $display("FAIL midrun_reset got=%b exp=%b", v, RESET_VEC); end
        RST = 1'b0;
        step(1);
        total++; if ({Stop, Busy} !== 2'b00) begin bad++; $display("FAIL post_reset got=%b exp=00", {Stop, Busy}); end
    endtask

    initial begin
        test_reset();
        test_mode_start();
        test_pause_stop();
        test_glitch_noload();
        test_finish();
        test_failure_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
